uart_rx_frontend: RTL and testbench
===================================

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning system clocks per UART bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of the rx input synchroniser.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is rising-edge on clk.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, asynchronous UART line; idle high; 8N1 framing; LSB first.
REQ-006 SHALL have port bit_out, output, 1, the most recently sampled data bit; feeds sipo_reg serial_in.
REQ-007 SHALL have port bit_tick, output, 1, one-cycle strobe marking bit_out valid; feeds the sipo_reg shift enable.
REQ-008 SHALL have port byte_done, output, 1, one-cycle strobe when a stop bit is sampled high.
REQ-009 SHALL have port frame_error, output, 1, one-cycle strobe when a stop bit is sampled low.
REQ-010 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-011 SHALL pass rx through SYNC_STAGES flops, each reset to 1; only the synchronised value rx_s is used internally.
REQ-012 SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-013 In IDLE, rx_s == 0 SHALL move to START with cnt cleared to 0.
REQ-014 In START, cnt SHALL count up; at cnt == CLKS_PER_BIT/2 - 1 (integer division), rx_s == 0 SHALL move to DATA with cnt = 0 and bit_idx = 0.
REQ-015 In START at that same count, rx_s == 1 is a glitch and SHALL return to IDLE with no strobe.
REQ-016 In DATA, at cnt == CLKS_PER_BIT - 1 the block SHALL register bit_out <= rx_s, pulse bit_tick for exactly one cycle coincident with the new bit_out, clear cnt and increment bit_idx.
REQ-017 After the tick with bit_idx == 7, the block SHALL enter STOP.
REQ-018 In STOP, at cnt == CLKS_PER_BIT - 1, rx_s == 1 SHALL pulse byte_done and go to IDLE.
REQ-019 In STOP, at cnt == CLKS_PER_BIT - 1, rx_s == 0 SHALL pulse frame_error and go to BREAK.
REQ-020 BREAK SHALL hold until rx_s == 1, then go to IDLE; no bit_tick is emitted in BREAK.
REQ-021 Exactly 8 bit_tick pulses SHALL occur per accepted frame, spaced CLKS_PER_BIT cycles apart.
REQ-022 The first bit_tick SHALL occur SYNC_STAGES + CLKS_PER_BIT/2 + CLKS_PER_BIT + 1 cycles after the rx falling edge, +/-1 cycle.
REQ-023 byte_done and frame_error SHALL be mutually exclusive and never coincide with bit_tick.
REQ-024 A new start bit SHALL be accepted on the first IDLE cycle after byte_done, so back-to-back frames need no extra idle time.
REQ-025 cnt SHALL be $clog2(CLKS_PER_BIT) bits wide and bit_idx 3 bits wide; neither wraps within a state.
REQ-026 Changes on rx during DATA or STOP between sample points SHALL have no effect.

Reset
REQ-027 On reset_n low the block SHALL, asynchronously: enter IDLE; clear cnt and bit_idx; set the synchroniser flops to 1; set bit_out = 0, bit_tick = 0, byte_done = 0, frame_error = 0 and busy = 0.
REQ-028 On reset release during a frame, the block SHALL wait in IDLE for a fresh falling edge; the partial frame produces no strobes.

Structure
REQ-029 The state encoding (typedef of the five states) and the constant DATA_BITS = 8 SHALL live in the shared package uart_pkg.
REQ-030 The synchroniser SHALL be a separate sub-module, sync_ff, parameterised by depth and reset value.
REQ-031 The FSM, counters and output registers SHALL stay in uart_rx_frontend.
REQ-032 The outputs SHALL feed sipo_reg directly, with no glue logic.

Verification (CLKS_PER_BIT = 16)
REQ-033 Frame 0xD6 with a valid stop bit SHALL produce bit_tick x8 with bit_out = 0,1,1,0,1,0,1,1, then one byte_done and no frame_error; a chained sipo_reg shows 0x6B (MSB-first shift of the LSB-first stream).
REQ-034 A 5-cycle low glitch on idle rx SHALL produce no bit_tick, with busy returning to 0 within 8 cycles.
REQ-035 Frame 0x00 with stop bit low for 40 cycles SHALL produce 8 ticks, one frame_error, no byte_done, and busy high until 3 cycles after rx returns high.
REQ-036 Back-to-back frames 0x55 then 0xAA SHALL produce 16 ticks with bits 1,0,1,0,1,0,1,0,0,1,0,1,0,1,0,1 and two byte_done pulses.
REQ-037 reset_n asserted after the 3rd tick of frame 0xFF, then released with rx high, SHALL force all outputs to 0 immediately, produce no strobes until the next frame, and a following 0x3C SHALL decode correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding
// and frame geometry.
package uart_pkg;

  // Number of data bits in an 8N1 frame.
  localparam int DATA_BITS = 8;

  // Receiver states. BREAK parks the receiver while the line is held low
  // after a failed stop bit, so a long break is not read as a new start bit.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage : uart_pkg

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser for a single asynchronous input.
// Every stage is forced to RESET_VAL while reset is asserted.
module sync_ff #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] stage_q;

  if (DEPTH == 1) begin : g_single
    // Single stage: capture the input directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stage_q <= RESET_VAL;
      else         stage_q <= d_i;
    end
  end else begin : g_chain
    // Shift the input through the chain; the oldest sample sits in the MSB.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stage_q <= {DEPTH{RESET_VAL}};
      else         stage_q <= {stage_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule : sync_ff

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front end. Synchronises the line, finds the start bit,
// samples each data bit mid-bit and presents it as a serial bit plus strobe
// for a downstream shift register.
//
// Output contract: bit_tick, byte_done and frame_error are single-cycle
// strobes with no back-pressure; bit_out is valid in the cycle bit_tick is
// high and holds its value until the next tick. At most one strobe is high
// in any cycle.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx,
  output logic bit_out,
  output logic bit_tick,
  output logic byte_done,
  output logic frame_error,
  output logic busy
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_tick_q, bit_tick_d;
  logic             byte_done_q, byte_done_d;
  logic             frame_error_q, frame_error_d;

  sync_ff #(
    .DEPTH     (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      bit_out_q     <= 1'b0;
      bit_tick_q    <= 1'b0;
      byte_done_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      bit_out_q     <= bit_out_d;
      bit_tick_q    <= bit_tick_d;
      byte_done_q   <= byte_done_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Next-state logic: the line is only looked at on sample counts, so edges
  // between sample points cannot disturb a frame in progress.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    bit_out_d     = bit_out_q;
    bit_tick_d    = 1'b0;
    byte_done_d   = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          bit_out_d  = rx_s;
          bit_tick_d = 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            state_d   = ST_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  assign bit_out     = bit_out_q;
  assign bit_tick    = bit_tick_q;
  assign byte_done   = byte_done_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != ST_IDLE);

endmodule : uart_rx_frontend

// File: tb/tb_uart_rx_frontend.sv
// Testbench for uart_rx_frontend at CLKS_PER_BIT = 16.
module tb_uart_rx_frontend;

  localparam int CPB  = 16;
  localparam int SYNC = 2;

  // Expected-event encoding: {kind[1:0], data[7:0]}.
  localparam logic [1:0] K_TICK = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;
  localparam logic [1:0] K_FERR = 2'd3;

  logic clk;
  logic reset_n;
  logic rx;
  logic bit_out;
  logic bit_tick;
  logic byte_done;
  logic frame_error;
  logic busy;

  int n_tests;
  int n_fail;
  int cyc;
  int fall_cyc;

  logic [9:0] exp_q[$];

  // Monitor-side state.
  int         tick_in_frame;
  int         last_tick_cyc;
  logic [7:0] sipo;

  uart_rx_frontend #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .bit_out     (bit_out),
    .bit_tick    (bit_tick),
    .byte_done   (byte_done),
    .frame_error (frame_error),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // What a shift register fed MSB-first from the LSB-first bit stream holds
  // after eight shifts: the byte with its bit order reversed.
  function automatic logic [7:0] sipo_image(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r = r + (8'((b >> i) & 8'h01) << (7 - i));
    return r;
  endfunction

  task automatic expect_frame(input logic [7:0] b, input bit stop_ok);
    for (int i = 0; i < 8; i++) exp_q.push_back({K_TICK, 7'd0, b[i]});
    if (stop_ok) exp_q.push_back({K_DONE, sipo_image(b)});
    else         exp_q.push_back({K_FERR, 8'h00});
  endtask

  // ---------------- driver tasks ----------------
  // All driver tasks start and end on a falling clock edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_data(input logic [7:0] b);
    fall_cyc = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
  endtask

  task automatic send_frame(input logic [7:0] b);
    expect_frame(b, 1'b1);
    drive_data(b);
    hold(1'b1, CPB);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check_pop(input string name, input logic [9:0] act);
    logic [9:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got event %h at cycle %0d, required no event", name, act, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        n_fail++;
        $display("FAIL %s: got event %h at cycle %0d, required %h", name, act, cyc, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      tick_in_frame = 0;
      sipo          = 8'h00;
    end else if (bit_tick || byte_done || frame_error) begin
      n_tests++;
      if ((int'(bit_tick) + int'(byte_done) + int'(frame_error)) != 1) begin
        n_fail++;
        $display("FAIL strobe_excl: got tick/done/ferr %b%b%b, required one-hot",
                 bit_tick, byte_done, frame_error);
      end
      if (bit_tick) begin
        sipo = {sipo[6:0], bit_out};
        check_pop("bit_tick", {K_TICK, 7'd0, bit_out});
        n_tests++;
        if (tick_in_frame == 0) begin
          if ((cyc - fall_cyc) < 26 || (cyc - fall_cyc) > 28) begin
            n_fail++;
            $display("FAIL first_tick_latency: got %0d cycles, required 26..28", cyc - fall_cyc);
          end
        end else if ((cyc - last_tick_cyc) != CPB) begin
          n_fail++;
          $display("FAIL tick_spacing: got %0d cycles, required %0d", cyc - last_tick_cyc, CPB);
        end
        tick_in_frame = tick_in_frame + 1;
        last_tick_cyc = cyc;
      end
      if (byte_done) begin
        check_pop("byte_done", {K_DONE, sipo});
        tick_in_frame = 0;
      end
      if (frame_error) begin
        check_pop("frame_error", {K_FERR, 8'h00});
        tick_in_frame = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    int         gap;
    int         glen;

    n_tests       = 0;
    n_fail        = 0;
    cyc           = 0;
    fall_cyc      = 0;
    tick_in_frame = 0;
    last_tick_cyc = 0;
    sipo          = 8'h00;
    rx            = 1'b1;
    reset_n       = 1'b0;

    repeat (4) @(negedge clk);
    check("rst_bit_out",     {7'd0, bit_out},     8'h00);
    check("rst_bit_tick",    {7'd0, bit_tick},    8'h00);
    check("rst_byte_done",   {7'd0, byte_done},   8'h00);
    check("rst_frame_error", {7'd0, frame_error}, 8'h00);
    check("rst_busy",        {7'd0, busy},        8'h00);
    reset_n = 1'b1;
    hold(1'b1, 10);
    check("idle_busy", {7'd0, busy}, 8'h00);

    // Known frame with valid stop bit.
    send_frame(8'hD6);
    hold(1'b1, 5);

    // Short low glitch on an idle line.
    hold(1'b0, 5);
    check("glitch_busy_high", {7'd0, busy}, 8'h01);
    hold(1'b1, 8);
    check("glitch_busy_low", {7'd0, busy}, 8'h00);
    hold(1'b1, 6);

    // Frame with stop bit held low for 40 cycles.
    expect_frame(8'h00, 1'b0);
    drive_data(8'h00);
    hold(1'b0, 40);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("break_busy_held", {7'd0, busy}, 8'h01);
    @(negedge clk);
    check("break_busy_release", {7'd0, busy}, 8'h00);
    hold(1'b1, 10);

    // Back-to-back frames with no idle gap.
    send_frame(8'h55);
    send_frame(8'hAA);
    hold(1'b1, 5);

    // Reset in the middle of a frame, after the third tick.
    exp_q.push_back({K_TICK, 8'h01});
    exp_q.push_back({K_TICK, 8'h01});
    exp_q.push_back({K_TICK, 8'h01});
    fall_cyc = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 3; i++) hold(1'b1, CPB);
    hold(1'b1, 2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_bit_out",     {7'd0, bit_out},     8'h00);
    check("mid_rst_bit_tick",    {7'd0, bit_tick},    8'h00);
    check("mid_rst_byte_done",   {7'd0, byte_done},   8'h00);
    check("mid_rst_frame_error", {7'd0, frame_error}, 8'h00);
    check("mid_rst_busy",        {7'd0, busy},        8'h00);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    hold(1'b1, 60);
    check("post_rst_busy", {7'd0, busy}, 8'h00);
    send_frame(8'h3C);
    hold(1'b1, 3);

    // Random frames, gaps and glitches.
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        glen = $urandom_range(1, 6);
        hold(1'b0, glen);
        hold(1'b1, 12);
      end
      b = 8'($urandom_range(0, 255));
      send_frame(b);
      gap = $urandom_range(0, 12);
      if (gap > 0) hold(1'b1, gap);
    end

    // Drain the scoreboard.
    for (int w = 0; w < 60 && exp_q.size() != 0; w++) @(negedge clk);
    hold(1'b1, 30);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d events still outstanding, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_frontend
